// File: rtl/mc_add_sched_pkg.sv
// Shared types and constants for the multicycle-adder scheduler.
//   state_t   : sequencer states (IDLE, HOLD, DONE)
//   cnt_width : width of the hold counter for a given MC_CYCLES
//   DEF_*     : default parameter values used by the top and the arbiter
package mc_add_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MC_CYCLES = 2;

    // Counter must hold values 0..MC_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int mc_cycles);
        int w;
        w = $clog2(mc_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mc_add_scheduler_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
//   req   : request vector, one bit per requester
//   ptr   : index with highest priority this cycle (search goes upward, wraps)
//   en    : when low no grant is issued
//   grant : one-hot grant (all zero when nothing granted)
//   idx   : binary index of the granted requester (0 when nothing granted)
// The pointer register lives in the instantiating module.
module rr_arbiter
    import mc_add_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin : arb_search
        int               j;
        logic [IDX_W-1:0] jj;
        logic             found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Candidate index ptr+i, wrapped into 0..NUM_REQ-1 without a modulo.
            j = int'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            jj = IDX_W'(j);
            if (en && !found && req[jj]) begin
                grant[jj] = 1'b1;
                idx       = jj;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mc_add_scheduler.sv
// Multicycle shared-adder scheduler.
// One combinational DATA_W-bit adder is shared by NUM_REQ requesters. The
// adder inputs come only from operand registers, which stay frozen for
// MC_CYCLES clocks before the result register is enabled, so the adder can be
// constrained as an MC_CYCLES multicycle path in STA.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake, req_ready is a one-hot grant
//   req_a/req_b         : flattened operands, requester i at [i*DATA_W +: DATA_W]
//   resp_valid/ready    : result handshake
//   resp_id, resp_data  : owner index and (A+B) mod 2^DATA_W
//   capture_ce          : result-register enable strobe
// Optional build macro MC_ADD_SCHED_STATS_EN adds:
//   op_count            : completed response handshakes (wraps at 2^32)
//   busy                : high whenever the sequencer is not IDLE
module mc_add_scheduler
    import mc_add_sched_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MC_CYCLES = DEF_MC_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]     req_a,
    input  logic [NUM_REQ*DATA_W-1:0]     req_b,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    resp_id,
    output logic [DATA_W-1:0]             resp_data,
    output logic                          capture_ce
`ifdef MC_ADD_SCHED_STATS_EN
    ,
    output logic [31:0]                   op_count,
    output logic                          busy
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(MC_CYCLES);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic [DATA_W-1:0]  sum;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_ptr_nxt;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               arb_en;
    logic               accept;
    logic               capture;

    assign arb_en = (state == IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .en    (arb_en),
        .grant (gnt),
        .idx   (gnt_idx)
    );

    // The adder sees only the frozen operand registers: this is the multicycle path.
    assign sum = op_a + op_b;

    assign accept  = arb_en && (|gnt);
    assign capture = (state == HOLD) && (cnt == '0);

    assign rr_ptr_nxt = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        capture_ce = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = gnt;
                if (accept) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                capture_ce = capture;
                if (capture) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rr_ptr    <= '0;
            resp_id   <= '0;
            resp_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_a    <= req_a[int'(gnt_idx)*DATA_W +: DATA_W];
                op_b    <= req_b[int'(gnt_idx)*DATA_W +: DATA_W];
                resp_id <= gnt_idx;
                cnt     <= CNT_W'(MC_CYCLES - 1);
                rr_ptr  <= rr_ptr_nxt;
            end else if ((state == HOLD) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (capture) begin
                resp_data <= sum;
            end
        end
    end

`ifdef MC_ADD_SCHED_STATS_EN
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            op_count <= '0;
        end else if ((state == DONE) && resp_ready) begin
            op_count <= op_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_add_scheduler.sv
// Bench for mc_add_scheduler: two instances (MC_CYCLES=2 and MC_CYCLES=1),
// a transaction-level model checked every cycle, plus directed literal checks.
module tb_mc_add_scheduler;

    localparam int NR = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NR-1:0]    rv0, rdy0, rv1, rdy1;
    logic [NR*DW-1:0] a0, b0, a1, b1;
    logic             vld0, rr0, cce0, vld1, rr1, cce1;
    logic [1:0]       id0, id1;
    logic [DW-1:0]    d0, d1;
`ifdef MC_ADD_SCHED_STATS_EN
    logic [31:0]      opc0, opc1;
    logic             busy0, busy1;
`endif

    mc_add_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .MC_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset), .req_valid(rv0), .req_ready(rdy0),
        .req_a(a0), .req_b(b0), .resp_valid(vld0), .resp_ready(rr0),
        .resp_id(id0), .resp_data(d0), .capture_ce(cce0)
`ifdef MC_ADD_SCHED_STATS_EN
        , .op_count(opc0), .busy(busy0)
`endif
    );

    mc_add_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .MC_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(rdy1),
        .req_a(a1), .req_b(b1), .resp_valid(vld1), .resp_ready(rr1),
        .resp_id(id1), .resp_data(d1), .capture_ce(cce1)
`ifdef MC_ADD_SCHED_STATS_EN
        , .op_count(opc1), .busy(busy1)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: an operation is either absent or has an age in
    // cycles since acceptance; capture at age MC, response from age MC+1.
    int          m_mc[2]   = '{2, 1};
    bit          m_busy[2] = '{0, 0};
    int          m_age[2]  = '{0, 0};
    int          m_ptr[2]  = '{0, 0};
    int          m_id[2]   = '{0, 0};
    logic [31:0] m_sum[2]  = '{32'd0, 32'd0};
    bit          chk_en    = 1'b0;
    int          acc_cyc[$];
    int          hs_id[$];

    task automatic model_cycle(input int k, input logic [3:0] rv, input logic [127:0] a,
                               input logic [127:0] b, input logic rr, input logic [3:0] rdy,
                               input logic cce, input logic vld, input logic [1:0] id,
                               input logic [31:0] dat);
        int       g;
        logic [3:0] eg;
        bit       ev_cap, ev_vld;
        g  = -1;
        eg = 4'h0;
        if (!m_busy[k]) begin
            for (int i = 0; i < NR; i++) begin
                int j;
                j = (m_ptr[k] + i) % NR;
                if (g < 0 && rv[j]) g = j;
            end
        end
        if (g >= 0) eg = 4'h1 << g;
        ev_cap = m_busy[k] && (m_age[k] == m_mc[k]);
        ev_vld = m_busy[k] && (m_age[k] > m_mc[k]);
        chk($sformatf("req_ready%0d", k), 32'(rdy), 32'(eg));
        chk($sformatf("capture_ce%0d", k), 32'(cce), 32'(ev_cap));
        chk($sformatf("resp_valid%0d", k), 32'(vld), 32'(ev_vld));
        if (ev_vld) begin
            chk($sformatf("resp_data%0d", k), dat, m_sum[k]);
            chk($sformatf("resp_id%0d", k), 32'(id), 32'(m_id[k]));
        end
        if (k == 0) begin
            if (g >= 0) acc_cyc.push_back(cyc);
            if (ev_vld && rr) hs_id.push_back(m_id[k]);
        end
        if (reset) begin
            m_busy[k] = 1'b0;
            m_age[k]  = 0;
            m_ptr[k]  = 0;
        end else if (g >= 0) begin
            m_busy[k] = 1'b1;
            m_age[k]  = 1;
            m_id[k]   = g;
            m_sum[k]  = a[g*32 +: 32] + b[g*32 +: 32];
            m_ptr[k]  = (g + 1) % NR;
        end else if (m_busy[k]) begin
            if (ev_vld && rr) m_busy[k] = 1'b0;
            else m_age[k] = m_age[k] + 1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            model_cycle(0, rv0, a0, b0, rr0, rdy0, cce0, vld0, id0, d0);
            model_cycle(1, rv1, a1, b1, rr1, rdy1, cce1, vld1, id1, d1);
        end
    end

    // One operation on dut0: present request, wait for grant, wait for result.
    task automatic do_op0(input int idx, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res);
        bit got;
        res = 32'hDEAD_BEEF;
        a0[idx*32 +: 32] = a;
        b0[idx*32 +: 32] = b;
        rv0 = 4'h1 << idx;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (rdy0[2'(idx)]) got = 1'b1;
        end
        chk("op_grant_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        rv0 = 4'h0;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (vld0) begin
                got = 1'b1;
                res = d0;
            end
        end
        chk("op_resp_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          t;
        int          exp_ids[5] = '{0, 1, 2, 3, 0};
        logic [31:0] r;
        bit          got;

        reset = 1'b1;
        rv0 = '0; rv1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        rr0 = 1'b1; rr1 = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_resp_valid", 32'(vld0), 32'd0);
        chk("rst_req_ready", 32'(rdy0), 32'd0);
        chk("rst_capture_ce", 32'(cce0), 32'd0);
        chk("rst_resp_data", d0, 32'd0);
        chk("rst_resp_id", 32'(id0), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // All requesters continuously valid: ids 0,1,2,3,0, one op per 4 cycles.
        for (int i = 0; i < NR; i++) begin
            a0[i*32 +: 32] = 32'(i * 16 + 1);
            b0[i*32 +: 32] = 32'd100;
        end
        hs_id.delete();
        acc_cyc.delete();
        rv0 = 4'hF;
        begin
            int n;
            n = 0;
            while (hs_id.size() < 5 && n < 100) begin
                @(posedge clk);
                n++;
            end
        end
        #1;
        rv0 = 4'h0;
        chk("rr_count", 32'(hs_id.size()), 32'd5);
        if (hs_id.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk($sformatf("rr_id%0d", i), 32'(hs_id[i]), 32'(exp_ids[i]));
        end
        if (acc_cyc.size() >= 5) begin
            for (int i = 1; i < 5; i++)
                chk($sformatf("rr_spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd4);
        end

        // Requester 1: 5 + 7, latency T / T+2 / T+3; operands changed after accept.
        a0[63:32] = 32'd5;
        b0[63:32] = 32'd7;
        rv0 = 4'b0010;
        t = cyc;
        @(negedge clk);
        chk("t1_ready", 32'(rdy0), 32'h2);
        @(posedge clk); #1;
        rv0 = 4'h0;
        a0[63:32] = 32'd99;
        b0[63:32] = 32'd99;
        @(negedge clk);
        chk("t1_cce_early", 32'(cce0), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_cce", 32'(cce0), 32'd1);
        chk("t1_cce_cycle", 32'(cyc - t), 32'd2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_valid", 32'(vld0), 32'd1);
        chk("t1_data", d0, 32'd12);
        chk("t1_id", 32'(id0), 32'd1);
        chk("t1_valid_cycle", 32'(cyc - t), 32'd3);
        @(posedge clk); #1;

        // Carry-out discarded.
        do_op0(0, 32'hFFFF_FFFF, 32'h1, r);
        chk("ovf_ff_1", r, 32'h0);
        do_op0(3, 32'h8000_0000, 32'h8000_0000, r);
        chk("ovf_80_80", r, 32'h0);
        do_op0(2, 32'h1234_5678, 32'h0FED_CBA9, r);
        chk("sum_mixed", r, 32'h2222_2221);

        // Stall in DONE for 5 cycles while another requester waits.
        rr0 = 1'b0;
        a0[63:32] = 32'd10;
        b0[63:32] = 32'd20;
        rv0 = 4'b0010;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (rdy0[1]) got = 1'b1;
        end
        chk("stall_grant_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        rv0 = 4'b1000;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (vld0) got = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("stall_resp_seen", 32'(got), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 32'(vld0), 32'd1);
            chk("stall_data", d0, 32'd30);
            chk("stall_id", 32'(id0), 32'd1);
            chk("stall_ready_low", 32'(rdy0), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
        end
        rr0 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_hs_ready", 32'(rdy0), 32'h8);
        @(posedge clk); #1;
        rv0 = 4'h0;
        repeat (5) @(posedge clk);
        #1;

        // Reset during HOLD: operation dropped, pointer back to 0.
        rv0 = 4'b0010;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (rdy0[1]) got = 1'b1;
        end
        chk("rst_op_grant_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        rv0 = 4'h0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rv0 = 4'b0100;
        @(negedge clk);
        chk("rst_mid_valid", 32'(vld0), 32'd0);
        chk("rst_mid_grant2", 32'(rdy0), 32'h4);
        @(posedge clk); #1;
        rv0 = 4'h0;
        repeat (6) @(posedge clk);
        #1;

        // MC_CYCLES=1 instance: 3 + 4, capture T+1, response T+2.
        a1[31:0] = 32'd3;
        b1[31:0] = 32'd4;
        rv1 = 4'b0001;
        t = cyc;
        @(negedge clk);
        chk("mc1_ready", 32'(rdy1), 32'h1);
        @(posedge clk); #1;
        rv1 = 4'h0;
        a1[31:0] = 32'd100;
        b1[31:0] = 32'd200;
        @(negedge clk);
        chk("mc1_cce", 32'(cce1), 32'd1);
        chk("mc1_valid_early", 32'(vld1), 32'd0);
        chk("mc1_cce_cycle", 32'(cyc - t), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mc1_valid", 32'(vld1), 32'd1);
        chk("mc1_data", d1, 32'd7);
        chk("mc1_id", 32'(id1), 32'd0);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
